// File: rtl/pe_core_single.sv
// pe_core_single: single-cycle processing element with a 32-bit ALU.
// Operands are sampled on a valid_in edge and the registered result appears
// one cycle later. Register fields and spare bits of the opcode are ignored.
// Optional feature: define PE_CORE_MAC_EN to build the multiplier (MUL, MAC);
// without it those funcs return 0 like any unlisted func.
module pe_core_single (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] opcode,
    input  logic [31:0] op1,
    input  logic [31:0] op2,
    input  logic [31:0] op3,
    input  logic        valid_in,
    output logic [31:0] result_out,
    output logic        result_valid
);

    localparam logic [6:0] CLASS_ALU = 7'b0000001;

    typedef enum logic [4:0] {
        FN_ADD = 5'b00001,
        FN_SUB = 5'b00010,
        FN_MUL = 5'b00011,
        FN_AND = 5'b00100,
        FN_OR  = 5'b00101,
        FN_XOR = 5'b00110,
        FN_SLL = 5'b00111,
        FN_SRA = 5'b01000,
        FN_MAX = 5'b01001,
        FN_MAC = 5'b01010,
        FN_MIN = 5'b01011
    } func_e;

    logic [6:0]  op_class;
    logic [4:0]  op_func;
    logic [31:0] alu_res;
    logic [31:0] result_d, result_q;
    logic        valid_d, valid_q;

    assign op_class = opcode[31:25];
    assign op_func  = opcode[24:20];

`ifdef PE_CORE_MAC_EN
    logic [31:0] mul_res;
    logic [31:0] mac_res;
    logic        unused_fields;

    assign mul_res       = op1 * op2;
    assign mac_res       = mul_res + op3;
    assign unused_fields = ^opcode[19:0];
`else
    logic unused_fields;

    assign unused_fields = ^{opcode[19:0], op3};
`endif

    // Decode class/func and compute the combinational ALU result
    always_comb begin
        alu_res = '0;
        if (op_class == CLASS_ALU) begin
            case (op_func)
                FN_ADD: alu_res = op1 + op2;
                FN_SUB: alu_res = op1 - op2;
                FN_AND: alu_res = op1 & op2;
                FN_OR:  alu_res = op1 | op2;
                FN_XOR: alu_res = op1 ^ op2;
                FN_SLL: alu_res = op1 << op2[4:0];
                FN_SRA: alu_res = $unsigned($signed(op1) >>> op2[4:0]);
                FN_MAX: alu_res = ($signed(op1) > $signed(op2)) ? op1 : op2;
                FN_MIN: alu_res = ($signed(op1) < $signed(op2)) ? op1 : op2;
`ifdef PE_CORE_MAC_EN
                FN_MUL: alu_res = mul_res;
                FN_MAC: alu_res = mac_res;
`endif
                default: alu_res = '0;
            endcase
        end
    end

    // Next-state: capture a new result on valid_in, otherwise hold
    always_comb begin
        valid_d  = valid_in;
        result_d = valid_in ? alu_res : result_q;
    end

    // Output registers, cleared asynchronously by reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            result_q <= '0;
            valid_q  <= 1'b0;
        end else begin
            result_q <= result_d;
            valid_q  <= valid_d;
        end
    end

    assign result_out   = result_q;
    assign result_valid = valid_q;

endmodule

// File: tb/tb_pe_core_single.sv
// Scoreboard bench for pe_core_single: the driver pushes one expected
// {valid, result} entry per issued cycle, the monitor pops and compares
// one entry per clock edge.
module tb_pe_core_single;

    logic        clk;
    logic        rst_n;
    logic [31:0] opcode;
    logic [31:0] op1;
    logic [31:0] op2;
    logic [31:0] op3;
    logic        valid_in;
    logic [31:0] result_out;
    logic        result_valid;

    int unsigned checks;
    int unsigned errors;

    typedef struct {
        logic        v;
        logic [31:0] r;
        string       name;
    } exp_t;

    exp_t        sb_q[$];
    logic [31:0] last_r;

    pe_core_single dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .opcode       (opcode),
        .op1          (op1),
        .op2          (op2),
        .op3          (op3),
        .valid_in     (valid_in),
        .result_out   (result_out),
        .result_valid (result_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] mk_op(input logic [6:0] cls, input logic [4:0] fn,
                                          input logic [14:0] fields);
        return {cls, fn, fields, 5'd0};
    endfunction

    // Reference model: written from the instruction rules with plain integer arithmetic
    function automatic logic [31:0] model(input logic [31:0] opc, input logic [31:0] a,
                                          input logic [31:0] b, input logic [31:0] c);
        int               sa;
        int               sb;
        longint unsigned  wide;
        int unsigned      sh;
        logic [31:0]      r;
        sa = int'(a);
        sb = int'(b);
        sh = int'(b % 32);
        r  = 32'd0;
        if (opc[31:25] != 7'd1) return 32'd0;
        case (int'(opc[24:20]))
            1:  r = 32'((longint'(a) + longint'(b)) % (64'd1 << 32));
            2:  r = 32'((longint'(a) - longint'(b) + (64'd1 << 32)) % (64'd1 << 32));
`ifdef PE_CORE_MAC_EN
            3: begin
                wide = longint'(a) * longint'(b);
                r = 32'(wide % (64'd1 << 32));
            end
            10: begin
                wide = longint'(a) * longint'(b) + longint'(c);
                r = 32'(wide % (64'd1 << 32));
            end
`endif
            4:  r = a & b;
            5:  r = a | b;
            6:  r = a ^ b;
            7:  r = 32'((longint'(a) * (64'd1 << sh)) % (64'd1 << 32));
            8:  r = 32'(longint'(sa) >>> sh);
            9:  r = (sa > sb) ? a : b;
            11: r = (sa < sb) ? a : b;
            default: r = 32'd0;
        endcase
        return r;
    endfunction

    task automatic issue(input string name, input logic [31:0] opc, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] c, input logic v,
                         input logic [31:0] exp_r);
        exp_t e;
        @(negedge clk);
        opcode   = opc;
        op1      = a;
        op2      = b;
        op3      = c;
        valid_in = v;
        if (v) last_r = exp_r;
        e.v    = v;
        e.r    = last_r;
        e.name = name;
        sb_q.push_back(e);
    endtask

    task automatic idle(input string name);
        issue(name, $urandom, $urandom, $urandom, $urandom, 1'b0, 32'd0);
    endtask

    task automatic direct_check(input string name, input logic [31:0] exp_r, input logic exp_v);
        checks++;
        if (result_out !== exp_r || result_valid !== exp_v) begin
            errors++;
            $display("FAIL %s got valid=%0b result=%h want valid=%0b result=%h",
                     name, result_valid, result_out, exp_v, exp_r);
        end
    endtask

    // Monitor: one scoreboard entry is due after every edge with rst_n high
    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (rst_n && sb_q.size() > 0) begin
                e = sb_q.pop_front();
                checks++;
                if (result_valid !== e.v || result_out !== e.r) begin
                    errors++;
                    $display("FAIL %s got valid=%0b result=%h want valid=%0b result=%h",
                             e.name, result_valid, result_out, e.v, e.r);
                end
            end
        end
    end

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog time limit reached");
        $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
        $fatal(1, "timeout");
    end

    localparam logic [6:0] ALU = 7'b0000001;

    initial begin : driver
        logic [6:0]  cls;
        logic [4:0]  fn;
        logic [31:0] a, b, c, opc;
        logic        v;
        int unsigned drain;

        checks   = 0;
        errors   = 0;
        last_r   = 32'd0;
        opcode   = '0;
        op1      = '0;
        op2      = '0;
        op3      = '0;
        valid_in = 1'b0;
        rst_n    = 1'b0;
        #1;
        direct_check("reset_async", 32'd0, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        direct_check("reset_hold", 32'd0, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;

        // Directed examples
        issue("add_10_20", mk_op(ALU, 5'd1, 15'd0), 32'd10, 32'd20, 32'd0, 1'b1, 32'd30);
        idle("add_then_idle");
        issue("add_50_25", mk_op(ALU, 5'd1, {5'd1, 5'd2, 5'd3}), 32'd50, 32'd25, 32'd0, 1'b1, 32'd75);
        issue("sub_75_10", mk_op(ALU, 5'd2, 15'd0), 32'd75, 32'd10, 32'd0, 1'b1, 32'd65);
        issue("sub_0_1", mk_op(ALU, 5'd2, 15'd0), 32'd0, 32'd1, 32'd0, 1'b1, 32'hFFFF_FFFF);
        idle("hold_after_sub");
        issue("and", mk_op(ALU, 5'd4, 15'd0), 32'h0000_F0F0, 32'h0000_FF00, 32'd0, 1'b1, 32'h0000_F000);
        issue("sra", mk_op(ALU, 5'd8, 15'd0), 32'h8000_0000, 32'd4, 32'd0, 1'b1, 32'hF800_0000);
        issue("max", mk_op(ALU, 5'd9, 15'd0), 32'hFFFF_FFFB, 32'd3, 32'd0, 1'b1, 32'd3);
        issue("min", mk_op(ALU, 5'd11, 15'd0), 32'hFFFF_FFFB, 32'd3, 32'd0, 1'b1, 32'hFFFF_FFFB);
`ifdef PE_CORE_MAC_EN
        issue("mac", mk_op(ALU, 5'd10, 15'd0), 32'd6, 32'd7, 32'd8, 1'b1, 32'd50);
        issue("mul", mk_op(ALU, 5'd3, 15'd0), 32'd6, 32'd7, 32'd0, 1'b1, 32'd42);
`else
        issue("mac", mk_op(ALU, 5'd10, 15'd0), 32'd6, 32'd7, 32'd8, 1'b1, 32'd0);
        issue("mul", mk_op(ALU, 5'd3, 15'd0), 32'd6, 32'd7, 32'd0, 1'b1, 32'd0);
`endif
        issue("sll", mk_op(ALU, 5'd7, 15'd0), 32'h0000_0003, 32'd31, 32'd0, 1'b1, 32'h8000_0000);
        issue("xor", mk_op(ALU, 5'd6, 15'd0), 32'hAAAA_5555, 32'hFFFF_0000, 32'd0, 1'b1, 32'h5555_5555);
        issue("or", mk_op(ALU, 5'd5, 15'd0), 32'h0000_00F0, 32'h0000_000F, 32'd0, 1'b1, 32'h0000_00FF);
        issue("illegal_class", mk_op(7'b1111111, 5'd1, 15'd0), 32'd5, 32'd6, 32'd0, 1'b1, 32'd0);
        issue("illegal_func", mk_op(ALU, 5'd31, 15'd0), 32'd5, 32'd6, 32'd0, 1'b1, 32'd0);
        issue("b2b_add_1", mk_op(ALU, 5'd1, 15'd0), 32'd1, 32'd1, 32'd0, 1'b1, 32'd2);
        issue("b2b_add_2", mk_op(ALU, 5'd1, 15'd0), 32'd2, 32'd2, 32'd0, 1'b1, 32'd4);
        issue("b2b_add_3", mk_op(ALU, 5'd1, 15'd0), 32'd3, 32'd3, 32'd0, 1'b1, 32'd6);
        issue("add_wrap", mk_op(ALU, 5'd1, 15'd0), 32'hFFFF_FFFF, 32'd2, 32'd0, 1'b1, 32'd1);

        // Mid-cycle reset after a valid result, with an operation in flight
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        direct_check("reset_midcycle", 32'd0, 1'b0);
        @(negedge clk);
        opcode   = mk_op(ALU, 5'd1, 15'd0);
        op1      = 32'd100;
        op2      = 32'd100;
        valid_in = 1'b1;
        @(posedge clk);
        #1;
        direct_check("reset_discard", 32'd0, 1'b0);
        @(negedge clk);
        valid_in = 1'b0;
        rst_n    = 1'b1;
        last_r   = 32'd0;
        idle("post_reset_idle");
        issue("post_reset_add", mk_op(ALU, 5'd1, 15'd0), 32'd7, 32'd8, 32'd0, 1'b1, 32'd15);

        // Randomized traffic against the reference model
        for (int i = 0; i < 400; i++) begin
            cls = ($urandom_range(0, 7) == 0) ? 7'($urandom) : ALU;
            fn  = 5'($urandom_range(0, 15));
            a   = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 15)) : $urandom;
            b   = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 40)) : $urandom;
            c   = $urandom;
            v   = ($urandom_range(0, 3) != 0);
            opc = mk_op(cls, fn, 15'($urandom));
            issue("random", opc, a, b, c, v, model(opc, a, b, c));
        end
        idle("final_idle");

        drain = 0;
        while (sb_q.size() > 0 && drain < 20) begin
            @(posedge clk);
            drain++;
        end
        @(negedge clk);
        checks++;
        if (sb_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain got %0d pending want 0", sb_q.size());
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/pe_core_single.md
PE_CORE_SINGLE -- requirements
Module: pe_core_single

Interface
REQ-001 The module SHALL have no parameters; the data width is fixed at 32 bits.
REQ-002 clk  input  1  single clock; all state updates on its rising edge.
REQ-003 rst_n  input  1  reset, asynchronous assertion, active-low.
REQ-004 opcode  input  32  instruction word: [31:25] class, [24:20] func, [19:15]/[14:10]/[9:5] register fields, [4:0] spare.
REQ-005 op1  input  32  first operand.
REQ-006 op2  input  32  second operand.
REQ-007 op3  input  32  third operand, used only by MAC.
REQ-008 valid_in  input  1  operands and opcode valid this cycle.
REQ-009 result_out  output  32  registered result.
REQ-010 result_valid  output  1  result_out holds the result of the operation accepted on the previous edge.

Function
REQ-011 The block SHALL sample opcode/op1/op2/op3 on a rising clk edge with valid_in=1 and present the result on result_out with result_valid=1 immediately after that same edge (latency 1 cycle, no stall, one operation per cycle).
REQ-012 result_valid SHALL equal valid_in registered: it is 0 after any edge where valid_in=0.
REQ-013 result_out SHALL hold its last value while valid_in=0.
REQ-014 The register fields [19:5] and [4:0] SHALL be ignored by this block; operands come only from op1/op2/op3.
REQ-015 Class 7'b0000001 (ALU) SHALL decode func as:
- 00001 ADD: op1+op2
- 00010 SUB: op1-op2
- 00011 MUL: low 32 bits of op1*op2
- 00100 AND, 00101 OR, 00110 XOR (bitwise)
- 00111 SLL: op1 << op2[4:0]
- 01000 SRA: arithmetic op1 >> op2[4:0]
- 01001 MAX, 01011 MIN: signed compare
- 01010 MAC: low 32 bits of (op1*op2)+op3.
REQ-016 ADD, SUB, MUL and MAC SHALL wrap modulo 2^32 with no overflow flag.
REQ-017 An unlisted func, or any class other than 7'b0000001, SHALL produce result_out=0 with result_valid=1.
REQ-018 On back-to-back valid cycles, each result SHALL appear exactly one edge after its inputs, with no bubble.

Reset
REQ-019 While rst_n=0, result_out SHALL be 0 and result_valid SHALL be 0, asynchronously and regardless of clk.
REQ-020 Reset asserted during an operation SHALL discard it; the first valid_in edge after release SHALL be processed normally.

Configuration
REQ-021 Macro PE_CORE_MAC_EN defined: MUL and MAC SHALL be implemented per REQ-015.
REQ-022 PE_CORE_MAC_EN undefined: the multiplier SHALL be omitted, and funcs 00011 and 01010 SHALL return 0 with result_valid=1, like illegal funcs.

Verification
REQ-023 ADD: opcode class 0000001, func 00001, op1=10, op2=20, valid_in=1 for one cycle -> after that edge result_valid=1 and result_out=30; result_valid=0 on the following edge.
REQ-024 ADD: op1=50, op2=25, fields 1/2/3 -> result_out=75; SUB with op1=75, op2=10 -> 65; SUB with op1=0, op2=1 -> 0xFFFFFFFF.
REQ-025 Logic, shift and compare:
- AND 0xF0F0 with 0xFF00 -> 0xF000
- SRA 0x80000000 by 4 -> 0xF8000000
- MAX(-5, 3) -> 3
- MIN(-5, 3) -> 0xFFFFFFFB.
REQ-026 MAC: op1=6, op2=7, op3=8 -> 50 with PE_CORE_MAC_EN defined; -> 0 with the macro undefined.
REQ-027 Illegal class 7'b1111111 -> result_out=0, result_valid=1; three back-to-back ADDs (1+1, 2+2, 3+3) -> 2, 4, 6 on consecutive edges.
REQ-028 Reset: assert rst_n=0 mid-cycle after a valid result -> result_out=0 and result_valid=0 before the next edge.
